// File: rtl/usb_pkg.sv
// Shared USB definitions: sync byte, PID codes, CRC constants
// and the packet framer state encoding.
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h7F;

    localparam logic [1:0] PTYPE_SPECIAL   = 2'b00;
    localparam logic [1:0] PTYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PTYPE_HANDSHAKE = 2'b10;
    localparam logic [1:0] PTYPE_DATA      = 2'b11;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;
    localparam logic [3:0] PID_PRE   = 4'b1100;
    localparam logic [3:0] PID_SPLIT = 4'b1000;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [3:0] PID_RSVD  = 4'b0000;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_TOK0,
        S_TOK1,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_DRAIN,
        S_EOP,
        S_DONE
    } framer_state_t;

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte CRC16 step: folds a byte into the running CRC,
// least significant bit first.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // Serial CRC update unrolled over the eight data bits
    always_comb begin
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_packet_framer.sv
// Builds SYNC/PID/body/CRC/EOP byte streams for transmit_shift.
// Optional USB_FRAMER_CRC_INJECT_EN adds crc_inject to corrupt the first CRC byte.
module usb_packet_framer
    import usb_pkg::*;
#(
    parameter int MAX_BYTES  = 64,
    parameter int LEN_W      = $clog2(MAX_BYTES + 1),
    parameter int EOP_CYCLES = 24
) (
    input  logic             tb_clk,
    input  logic             tb_n_rst,
    input  logic             start,
    input  logic [3:0]       pid,
    input  logic [6:0]       addr,
    input  logic [3:0]       endp,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_load_enable,
    output logic             tx_eop,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef USB_FRAMER_CRC_INJECT_EN
    ,
    input  logic             crc_inject
`endif
);

    localparam int EOP_W = $clog2(EOP_CYCLES + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    framer_state_t    state;
    logic             armed;
    logic [3:0]       pid_q;
    logic [6:0]       addr_q;
    logic [3:0]       endp_q;
    logic [LEN_W-1:0] cnt_q;
    logic [15:0]      crc_q;
    logic [15:0]      crc_next;
    logic [EOP_W-1:0] eop_cnt;
    logic             err_q;
    logic             inject;
    logic [4:0]       crc5;
    logic [7:0]       byte_val;
    logic             byte_state;
    logic             load;

    function automatic logic [4:0] crc5_calc(input logic [6:0] a,
                                             input logic [3:0] e);
        logic [10:0] bits;
        logic [4:0]  c;
        bits = {e, a};
        c    = CRC5_INIT;
        for (int i = 0; i < 11; i++) begin
            if (c[4] ^ bits[i]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
            else                c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    assign crc5 = crc5_calc(addr_q, endp_q);

    usb_crc16_byte u_crc16 (
        .crc_in (crc_q),
        .data   (in_data),
        .crc_out(crc_next)
    );

`ifdef USB_FRAMER_CRC_INJECT_EN
    logic inject_q;

    // Hold the CRC corruption request for the packet being framed
    always_ff @(posedge tb_clk or negedge tb_n_rst) begin
        if (!tb_n_rst) inject_q <= 1'b0;
        else if (state == S_IDLE && start) inject_q <= crc_inject;
    end

    assign inject = inject_q;
`else
    assign inject = 1'b0;
`endif

    // Byte presented to the shifter in each byte-carrying state
    always_comb begin
        byte_state = 1'b1;
        byte_val   = 8'hFF;
        unique case (state)
            S_SYNC:   byte_val = SYNC_BYTE;
            S_PID:    byte_val = {pid_q, ~pid_q};
            S_TOK0:   byte_val = {endp_q[0], addr_q};
            S_TOK1:   byte_val = {crc5, endp_q[3:1]} ^ {4'b0, inject, 3'b0};
            S_DATA:   byte_val = in_data;
            S_CRC_LO: byte_val = ~crc_q[7:0] ^ {7'b0, inject};
            S_CRC_HI: byte_val = ~crc_q[15:8];
            default:  byte_state = 1'b0;
        endcase
    end

    assign load = byte_state & armed & tx_ready &
                  ((state != S_DATA) | in_valid);

    assign tx_data        = byte_val;
    assign tx_load_enable = load;
    assign in_ready       = load & (state == S_DATA);
    assign tx_eop         = (state == S_EOP);
    assign busy           = (state != S_IDLE) & (state != S_DONE);
    assign done           = (state == S_DONE);
    assign err            = err_q;

    // Packet sequencing, shifter pacing and payload CRC accumulation
    always_ff @(posedge tb_clk or negedge tb_n_rst) begin
        if (!tb_n_rst) begin
            state   <= S_IDLE;
            armed   <= 1'b1;
            pid_q   <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
            cnt_q   <= '0;
            crc_q   <= CRC16_INIT;
            eop_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!tx_ready) armed <= 1'b1;
            if (load)      armed <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    pid_q  <= pid;
                    addr_q <= addr;
                    endp_q <= endp;
                    cnt_q  <= (len > MAX_LEN) ? MAX_LEN : len;
                    err_q  <= (len > MAX_LEN);
                    crc_q  <= CRC16_INIT;
                    state  <= S_SYNC;
                end
                S_SYNC: if (load) state <= S_PID;
                S_PID: if (load) begin
                    unique case (pid_q[1:0])
                        PTYPE_DATA:
                            state <= (cnt_q == '0) ? S_CRC_LO : S_DATA;
                        PTYPE_HANDSHAKE: state <= S_DRAIN;
                        default:         state <= S_TOK0;
                    endcase
                end
                S_TOK0: if (load) state <= S_TOK1;
                S_TOK1: if (load) state <= S_DRAIN;
                S_DATA: if (load) begin
                    cnt_q <= cnt_q - LEN_W'(1);
                    crc_q <= crc_next;
                    if (cnt_q == LEN_W'(1)) state <= S_CRC_LO;
                end
                S_CRC_LO: if (load) state <= S_CRC_HI;
                S_CRC_HI: if (load) state <= S_DRAIN;
                S_DRAIN: if (armed && tx_ready) begin
                    eop_cnt <= EOP_W'(EOP_CYCLES - 1);
                    state   <= S_EOP;
                end
                S_EOP: begin
                    if (eop_cnt == '0) state <= S_DONE;
                    else eop_cnt <= eop_cnt - EOP_W'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_packet_framer.sv
// Randomized self-checking bench for usb_packet_framer with a
// transmit_shift pacing model and a byte-sequence reference model.
module tb_usb_packet_framer;

    localparam int LEN_W = 7;
    localparam int MAXB  = 64;

    logic             tb_clk = 1'b0;
    logic             tb_n_rst;
    logic             start;
    logic [3:0]       pid;
    logic [6:0]       addr;
    logic [3:0]       endp;
    logic [LEN_W-1:0] len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_load_enable;
    logic             tx_eop;
    logic             busy;
    logic             done;
    logic             err;
`ifdef USB_FRAMER_CRC_INJECT_EN
    logic             crc_inject = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] pay_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int exp_pay;
    int eop_cycles, done_cnt, inrdy_cnt, eop_bad, inrdy_bad;
    bit busy_at1, err_at_done, timed_out, post_done, post_busy;

    usb_packet_framer dut (
        .tb_clk        (tb_clk),
        .tb_n_rst      (tb_n_rst),
        .start         (start),
        .pid           (pid),
        .addr          (addr),
        .endp          (endp),
        .len           (len),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_load_enable(tx_load_enable),
        .tx_eop        (tx_eop),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef USB_FRAMER_CRC_INJECT_EN
        ,
        .crc_inject    (crc_inject)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    // Generic MSB-feedback CRC over a bit list, result complemented
    function automatic int crc_model(input bit bits[$], input int w,
                                     input int poly, input int init);
        int r;
        int mask;
        bit fb;
        r    = init;
        mask = (1 << w) - 1;
        foreach (bits[i]) begin
            fb = (((r >> (w - 1)) & 1) != 0) ^ bits[i];
            r  = (r << 1) & mask;
            if (fb) r = r ^ poly;
        end
        return (~r) & mask;
    endfunction

    task automatic build_expected(input logic [3:0] p, input logic [6:0] a,
                                  input logic [3:0] e, input int n);
        bit bits[$];
        int c;
        int k;
        exp_q   = {};
        exp_pay = 0;
        exp_q.push_back(8'h7F);
        exp_q.push_back({p, ~p});
        if (p[1:0] == 2'b11) begin
            k = (n > MAXB) ? MAXB : n;
            exp_pay = k;
            for (int i = 0; i < k; i++) begin
                exp_q.push_back(pay_q[i]);
                for (int b = 0; b < 8; b++) bits.push_back(pay_q[i][b]);
            end
            c = crc_model(bits, 16, 'h8005, 'hFFFF);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end else if (p[1:0] != 2'b10) begin
            for (int b = 0; b < 7; b++) bits.push_back(a[b]);
            for (int b = 0; b < 4; b++) bits.push_back(e[b]);
            c = crc_model(bits, 5, 'h05, 'h1F);
            exp_q.push_back({e[0], a});
            exp_q.push_back({c[4:0], e[3:1]});
        end
    endtask

    function automatic int seq_diff();
        int m;
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return m;
        return -1;
    endfunction

    function automatic logic [7:0] at(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    // One packet: drive the request, emulate the shifter, record loads
    task automatic run_packet(input logic [3:0] p, input logic [6:0] a,
                              input logic [3:0] e, input int n,
                              input int stall_at, input bit jitter,
                              input bit busy_start, input int abort_at);
        int idx, stall_left, sh_busy;
        bit stalled, seen_done;
        got_q = {};
        eop_cycles = 0; done_cnt = 0; inrdy_cnt = 0;
        eop_bad = 0; inrdy_bad = 0;
        busy_at1 = 0; err_at_done = 0; timed_out = 0;
        post_done = 0; post_busy = 0;
        idx = 0; stall_left = 0; sh_busy = 0;
        stalled = 0; seen_done = 0;
        for (int cyc = 0; cyc < 5000 && !seen_done; cyc++) begin
            @(negedge tb_clk);
            if (sh_busy > 0) sh_busy--;
            tx_ready = (sh_busy == 0);
            start = (cyc == 0) || (busy_start && cyc == 12);
            pid   = (cyc == 0) ? p : 4'b0010;
            addr  = (cyc == 0) ? a : ~a;
            endp  = (cyc == 0) ? e : ~e;
            len   = (cyc == 0) ? LEN_W'(n) : LEN_W'(3);
            if (stall_at >= 0 && !stalled && idx == stall_at) begin
                stalled = 1;
                stall_left = 50;
            end
            in_valid = (idx < pay_q.size()) && (stall_left == 0) &&
                       !(jitter && $urandom_range(0, 3) == 0);
            in_data = (idx < pay_q.size()) ? pay_q[idx] : 8'($urandom);
            if (stall_left > 0) stall_left--;
            #1;
            if (cyc == 1) busy_at1 = busy;
            if (tx_load_enable) begin
                got_q.push_back(tx_data);
                sh_busy = $urandom_range(2, 6);
                if (tx_eop) eop_bad++;
            end
            if (in_ready) begin
                inrdy_cnt++;
                if (!tx_load_enable || !in_valid || tx_data !== in_data)
                    inrdy_bad++;
                idx++;
            end
            if (tx_eop) begin
                eop_cycles++;
                if (tx_data !== 8'hFF) eop_bad++;
            end
            if (done) begin
                done_cnt++;
                err_at_done = err;
                seen_done = 1;
            end
            if (abort_at >= 0 && got_q.size() == abort_at) return;
        end
        start = 0;
        in_valid = 0;
        if (seen_done) begin
            @(negedge tb_clk);
            #1;
            post_done = done;
            post_busy = busy;
        end else begin
            timed_out = 1;
        end
    endtask

    task automatic test_reset;
        tb_n_rst = 0;
        start = 0; pid = 0; addr = 0; endp = 0; len = 0;
        in_data = 0; in_valid = 0; tx_ready = 1;
        repeat (3) @(negedge tb_clk);
        #1;
        checks++;
        if ({tx_load_enable, tx_eop, busy, done, err, in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 000000",
                     {tx_load_enable, tx_eop, busy, done, err, in_ready});
        end
        checks++;
        if (tx_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_tx_data: got %h want ff", tx_data);
        end
        @(negedge tb_clk);
        tb_n_rst = 1;
    endtask

    task automatic test_known;
        logic [3:0] tp[4];
        logic [6:0] ta[4];
        logic [3:0] te[4];
        int tn[4];
        int d;
        tp = '{4'b0011, 4'b1001, 4'b0010, 4'b0011};
        ta = '{7'h00, 7'h15, 7'h00, 7'h00};
        te = '{4'h0, 4'hE, 4'h0, 4'h0};
        tn = '{4, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            pay_q = {};
            for (int i = 0; i < tn[k]; i++) pay_q.push_back(8'(i));
            build_expected(tp[k], ta[k], te[k], tn[k]);
            run_packet(tp[k], ta[k], te[k], tn[k], -1, 0, 0, -1);
            d = seq_diff();
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL known%0d_seq: idx %0d got %h want %h (n %0d/%0d)",
                         k, d, at(got_q, d), at(exp_q, d),
                         got_q.size(), exp_q.size());
            end
            checks++;
            if (eop_cycles != 24 || eop_bad != 0) begin
                errors++;
                $display("FAIL known%0d_eop: got %0d cycles bad %0d want 24/0",
                         k, eop_cycles, eop_bad);
            end
            checks++;
            if (done_cnt != 1 || post_done || post_busy || timed_out) begin
                errors++;
                $display("FAIL known%0d_done: got %0d post %b/%b to %b want 1 0/0 0",
                         k, done_cnt, post_done, post_busy, timed_out);
            end
            checks++;
            if (inrdy_cnt != exp_pay || inrdy_bad != 0) begin
                errors++;
                $display("FAIL known%0d_in_ready: got %0d bad %0d want %0d/0",
                         k, inrdy_cnt, inrdy_bad, exp_pay);
            end
            checks++;
            if (!busy_at1 || err_at_done) begin
                errors++;
                $display("FAIL known%0d_flags: got busy %b err %b want 1 0",
                         k, busy_at1, err_at_done);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] p;
        logic [6:0] a;
        logic [3:0] e;
        int n, d;
        for (int k = 0; k < 8; k++) begin
            p = 4'($urandom);
            a = 7'($urandom);
            e = 4'($urandom);
            n = $urandom_range(0, 20);
            pay_q = {};
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            build_expected(p, a, e, n);
            run_packet(p, a, e, n, -1, 1, 0, -1);
            d = seq_diff();
            checks++;
            if (d != -1 || timed_out) begin
                errors++;
                $display("FAIL rand%0d_seq: pid %b idx %0d got %h want %h to %b",
                         k, p, d, at(got_q, d), at(exp_q, d), timed_out);
            end
            checks++;
            if (eop_cycles != 24 || done_cnt != 1 ||
                inrdy_cnt != exp_pay || inrdy_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_ctl: got eop %0d done %0d rdy %0d/%0d want 24 1 %0d/0",
                         k, eop_cycles, done_cnt, inrdy_cnt, inrdy_bad, exp_pay);
            end
        end
    endtask

    task automatic test_stall;
        int d;
        pay_q = {};
        for (int i = 0; i < 8; i++) pay_q.push_back(8'($urandom));
        build_expected(4'b1011, 7'h0, 4'h0, 8);
        run_packet(4'b1011, 7'h0, 4'h0, 8, 3, 0, 0, -1);
        d = seq_diff();
        checks++;
        if (d != -1 || timed_out) begin
            errors++;
            $display("FAIL stall_seq: idx %0d got %h want %h (n %0d/%0d)",
                     d, at(got_q, d), at(exp_q, d), got_q.size(), exp_q.size());
        end
        checks++;
        if (inrdy_cnt != 8 || inrdy_bad != 0) begin
            errors++;
            $display("FAIL stall_in_ready: got %0d bad %0d want 8/0",
                     inrdy_cnt, inrdy_bad);
        end
    endtask

    task automatic test_overflow;
        int d;
        pay_q = {};
        for (int i = 0; i < 100; i++) pay_q.push_back(8'($urandom));
        build_expected(4'b0011, 7'h0, 4'h0, 100);
        run_packet(4'b0011, 7'h0, 4'h0, 100, -1, 0, 1, -1);
        d = seq_diff();
        checks++;
        if (d != -1 || timed_out) begin
            errors++;
            $display("FAIL ovf_seq: idx %0d got %h want %h (n %0d/%0d)",
                     d, at(got_q, d), at(exp_q, d), got_q.size(), exp_q.size());
        end
        checks++;
        if (inrdy_cnt != 64) begin
            errors++;
            $display("FAIL ovf_payload: got %0d want 64", inrdy_cnt);
        end
        checks++;
        if (err_at_done !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL ovf_err: got err %b done %0d want 1 1",
                     err_at_done, done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        pay_q = {};
        for (int i = 0; i < 8; i++) pay_q.push_back(8'($urandom));
        run_packet(4'b0011, 7'h0, 4'h0, 8, -1, 0, 0, 4);
        tb_n_rst = 0;
        start = 0;
        #1;
        checks++;
        if ({tx_load_enable, tx_eop, busy, done, err, in_ready} !== 6'b0 ||
            tx_data !== 8'hFF || eop_cycles != 0) begin
            errors++;
            $display("FAIL mid_reset: got %b data %h eop %0d want 000000 ff 0",
                     {tx_load_enable, tx_eop, busy, done, err, in_ready},
                     tx_data, eop_cycles);
        end
        @(negedge tb_clk);
        tb_n_rst = 1;
        pay_q = {};
        for (int i = 0; i < 5; i++) pay_q.push_back(8'($urandom));
        build_expected(4'b0011, 7'h0, 4'h0, 5);
        run_packet(4'b0011, 7'h0, 4'h0, 5, -1, 0, 0, -1);
        d = seq_diff();
        checks++;
        if (d != -1 || timed_out || eop_cycles != 24) begin
            errors++;
            $display("FAIL mid_fresh: idx %0d got %h want %h eop %0d",
                     d, at(got_q, d), at(exp_q, d), eop_cycles);
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_random;
        test_stall;
        test_overflow;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
